// File: rtl/blink_pattern.sv
`default_nettype none
// ============================================================================
// Module      : blink_pattern
// Description : Animated LED pattern driver for lock completion. Patterns
//               step every PERIOD cycles while `complete` is non-zero.
//               Optional macro BLINK_BOUNCE_EN turns mode 11 into bounce.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_pattern #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 250000
) (
    input  logic             blink_clk,
    input  logic             blink_rst,
    input  logic [WIDTH-1:0] complete,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    localparam int                 c_CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam logic [1:0] c_MODE_CHASE = 2'b00;
    localparam logic [1:0] c_MODE_FLASH = 2'b01;
    localparam logic [1:0] c_MODE_FILL  = 2'b10;
`ifdef BLINK_BOUNCE_EN
    localparam logic [1:0] c_MODE_BOUNCE = 2'b11;
`endif

    localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   r_out;
    logic               r_wrap;

    logic               w_active;
    logic               w_tick;
    logic [WIDTH-1:0]   w_entry_start;
    logic [WIDTH-1:0]   w_run_start;
    logic [WIDTH-1:0]   w_next;
    logic               w_restart;

    assign w_active = |complete;
    assign w_tick   = (r_cnt == c_CNT_MAX);

    // Entry uses the live mode input; wrap detection uses the latched one.
    assign w_entry_start = (mode   == c_MODE_FLASH) ? c_ONES : c_ONE;
    assign w_run_start   = (r_mode == c_MODE_FLASH) ? c_ONES : c_ONE;
    assign w_restart     = (w_next == w_run_start);

`ifdef BLINK_BOUNCE_EN
    logic r_dir;
    logic w_next_dir;
`endif

    always_comb begin
        w_next = r_out[WIDTH-1] ? c_ONE : {r_out[WIDTH-2:0], 1'b0};
`ifdef BLINK_BOUNCE_EN
        w_next_dir = r_dir;
`endif
        case (r_mode)
            c_MODE_FLASH: begin
                w_next = ~r_out;
            end
            c_MODE_FILL: begin
                w_next = (r_out == c_ONES) ? '0 : {r_out[WIDTH-2:0], 1'b1};
            end
`ifdef BLINK_BOUNCE_EN
            c_MODE_BOUNCE: begin
                // r_dir=1 means moving right; flip at each end so ends are not repeated.
                w_next = r_dir ? {1'b0, r_out[WIDTH-1:1]} : {r_out[WIDTH-2:0], 1'b0};
                if (w_next == c_ONE) begin
                    w_next_dir = 1'b0;
                end else if (w_next[WIDTH-1]) begin
                    w_next_dir = 1'b1;
                end
            end
`endif
            default: begin
                w_next = r_out[WIDTH-1] ? c_ONE : {r_out[WIDTH-2:0], 1'b0};
            end
        endcase
    end

    always_ff @(posedge blink_clk or posedge blink_rst) begin
        if (blink_rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= c_MODE_CHASE;
            r_out   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    r_out <= '0;
                    if (w_active) begin
                        r_state <= c_ST_RUN;
                        r_mode  <= mode;
                        r_out   <= w_entry_start;
                    end
                end
                default: begin
                    // Dropping complete wins over a coincident tick.
                    if (!w_active) begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                        r_out   <= '0;
                    end else if (w_tick) begin
                        r_cnt  <= '0;
                        r_out  <= w_next;
                        r_wrap <= w_restart;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
            endcase
        end
    end

`ifdef BLINK_BOUNCE_EN
    always_ff @(posedge blink_clk or posedge blink_rst) begin
        if (blink_rst) begin
            r_dir <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            r_dir <= 1'b0;
        end else if (w_active && w_tick) begin
            r_dir <= w_next_dir;
        end
    end
`endif

    assign out  = r_out;
    assign wrap = r_wrap;

endmodule
`default_nettype wire
